// File: rtl/seq_detect_arbiter_if.sv
// Handshake bundle for the shared "01" detector: per-lane requests/data in,
// grants, detect flags, hit events and packed hit counters out.
interface seq_detect_arbiter_if #(
   parameter int CNT_W = 8
);
   logic [3:0]         req;
   logic [3:0]         A;
   logic [3:0]         chan_clr;
   logic [3:0]         gnt;
   logic [3:0]         Y;
   logic               hit_pulse;
   logic [1:0]         hit_ch;
   logic [4*CNT_W-1:0] hit_cnt;

   modport master (
      output req, A, chan_clr,
      input  gnt, Y, hit_pulse, hit_ch, hit_cnt
   );

   modport slave (
      input  req, A, chan_clr,
      output gnt, Y, hit_pulse, hit_ch, hit_cnt
   );
endinterface

// File: rtl/seq_detect_arbiter.sv
// One "01" detection FSM time-shared by four serial lanes through a
// round-robin arbiter; each lane keeps its own state, flag and hit counter.
module seq_detect_arbiter #(
   parameter int CNT_W = 8
) (
   input logic               clk,
   input logic               rst,
   seq_detect_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      SX = 2'b11
   } state_e;

   state_e           state_q [4];
   state_e           state_d [4];
   logic [CNT_W-1:0] cnt_q   [4];
   logic [CNT_W-1:0] cnt_d   [4];
   logic [1:0]       ptr_q, ptr_d;
   logic             hit_pulse_q, hit_pulse_d;
   logic [1:0]       hit_ch_q, hit_ch_d;

   logic [3:0]       elig;
   logic [3:0]       gnt;
   logic             gnt_vld;
   logic [1:0]       gidx;
   logic [1:0]       idx;
   state_e           nxt;

   function automatic state_e fsm_next(input state_e cur, input logic a);
      case (cur)
         S0:      return a ? S0 : S1;
         S1:      return a ? S2 : S1;
         S2:      return a ? S0 : S1;
         default: return S0;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
   endfunction

   // Rotating-priority search starting at ptr; cleared lanes are never eligible.
   always_comb begin
      elig    = bus.req & ~bus.chan_clr;
      gnt     = '0;
      gnt_vld = 1'b0;
      gidx    = '0;
      idx     = '0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!gnt_vld && elig[idx] && !rst) begin
            gnt_vld = 1'b1;
            gidx    = idx;
         end
      end
      if (gnt_vld) gnt[gidx] = 1'b1;
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
      end
      ptr_d       = ptr_q;
      hit_pulse_d = 1'b0;
      hit_ch_d    = hit_ch_q;
      nxt         = fsm_next(state_q[gidx], bus.A[gidx]);
      if (gnt_vld) begin
         state_d[gidx] = nxt;
         ptr_d         = gidx + 2'd1;
         if (nxt == S2 && state_q[gidx] != S2) begin
            hit_pulse_d = 1'b1;
            hit_ch_d    = gidx;
            cnt_d[gidx] = sat_inc(cnt_q[gidx]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (bus.chan_clr[i]) begin
            state_d[i] = S0;
            cnt_d[i]   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= S0;
            cnt_q[i]   <= '0;
         end
         ptr_q       <= '0;
         hit_pulse_q <= 1'b0;
         hit_ch_q    <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         ptr_q       <= ptr_d;
         hit_pulse_q <= hit_pulse_d;
         hit_ch_q    <= hit_ch_d;
      end
   end

   always_comb begin
      bus.hit_cnt = '0;
      bus.Y       = '0;
      for (int i = 0; i < 4; i++) begin
         bus.hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
         bus.Y[i]                      = (state_q[i] == S2);
      end
   end

   assign bus.gnt       = gnt;
   assign bus.hit_pulse = hit_pulse_q;
   assign bus.hit_ch    = hit_ch_q;

endmodule
